// File: rtl/c_result_reader.sv
// c_result_reader
//   Drains the C result buffer after a matmul run and streams it out as
//   WORD_W-bit words over valid/ready. Row indices are issued to the C buffer
//   (registered read, data one cycle later); each row is captured into a
//   two-slot prefetch buffer and emitted MSB word first.
//
// Ports
//   clk, rst        : clock, async active-high reset
//   start, num_rows : begin a drain of num_rows rows (sampled while idle)
//   busy, done      : drain in progress / one-cycle completion pulse
//   C_wr_en         : tied low, this block only reads
//   C_index         : row address to the C buffer
//   C_data_out      : row returned by the C buffer
//   out_valid/out_ready/out_data/out_last : word stream, last on final word
module c_result_reader #(
    parameter int N_COLS = 4,
    parameter int WORD_W = 32,
    parameter int ROW_W  = 128,
    parameter int IDX_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num_rows,
    output logic              busy,
    output logic              done,
    output logic              C_wr_en,
    output logic [IDX_W-1:0]  C_index,
    input  logic [ROW_W-1:0]  C_data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
);
    localparam int CW = $clog2(N_COLS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t state, state_nxt;

    logic [7:0]     rows_q;      // latched num_rows
    logic [7:0]     fetch_cnt;   // rows issued to the C buffer
    logic [7:0]     row_cnt;     // rows fully streamed out
    logic [CW-1:0]  word_cnt;    // word within head row

    logic [1:0][ROW_W-1:0] slot; // two-row prefetch buffer
    logic           wr_ptr, rd_ptr;
    logic [1:0]     held;        // rows sitting in slots
    logic           inflight;    // read issued last edge, data arriving now

    logic [N_COLS-1:0][WORD_W-1:0] head_words;

    logic start_ok, accept, row_done, last_row, issue;

    // Word 0 is the most significant field of the row.
    for (genvar c = 0; c < N_COLS; c++) begin : g_word
        assign head_words[c] = slot[rd_ptr][ROW_W-1-c*WORD_W -: WORD_W];
    end

    assign start_ok = start && (state != S_RUN);
    assign out_valid = (state == S_RUN) && (held != 2'd0);
    assign accept   = out_valid && out_ready;
    assign row_done = accept && (word_cnt == CW'(N_COLS-1));
    assign last_row = (row_cnt == rows_q - 8'd1);
    // Rows held plus the one in flight never exceed the two slots.
    assign issue    = (state == S_RUN) && ((held + {1'b0, inflight}) < 2'd2)
                      && (fetch_cnt < rows_q);

    assign out_data = out_valid ? head_words[word_cnt] : '0;
    assign out_last = row_done || (out_valid && (word_cnt == CW'(N_COLS-1)))
                      ? (out_valid && (word_cnt == CW'(N_COLS-1)) && last_row) : 1'b0;
    assign busy     = (state == S_RUN);
    assign done     = (state == S_FINISH);
    assign C_wr_en  = 1'b0;
    assign C_index  = {{(IDX_W-8){1'b0}}, fetch_cnt};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_FINISH: begin
                if (start)                 state_nxt = (num_rows == 8'd0) ? S_FINISH : S_RUN;
                else                       state_nxt = S_IDLE;
            end
            S_RUN: if (row_done && last_row) state_nxt = S_FINISH;
            default:                       state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q    <= '0;
            fetch_cnt <= '0;
            row_cnt   <= '0;
            word_cnt  <= '0;
            slot      <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            held      <= '0;
            inflight  <= 1'b0;
        end else if (start_ok) begin
            rows_q    <= num_rows;
            fetch_cnt <= '0;
            row_cnt   <= '0;
            word_cnt  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            held      <= '0;
            inflight  <= 1'b0;
        end else if (state == S_RUN) begin
            // The C buffer samples C_index on the issuing edge; its data is
            // on C_data_out during the next cycle and captured one edge later.
            inflight <= issue;
            if (issue) fetch_cnt <= fetch_cnt + 8'd1;
            if (inflight) begin
                slot[wr_ptr] <= C_data_out;
                wr_ptr       <= ~wr_ptr;
            end
            if (accept) word_cnt <= word_cnt + 1'b1;
            if (row_done) begin
                rd_ptr  <= ~rd_ptr;
                row_cnt <= row_cnt + 8'd1;
            end
            case ({inflight, row_done})
                2'b10:   held <= held + 2'd1;
                2'b01:   held <= held - 2'd1;
                default: held <= held;
            endcase
        end
    end
endmodule
